// File: rtl/lobby_controller.sv
// Lobby controller: team-name editor, confirm gate, timed intro, play start.
// Edits one character at a time with auto-repeat; a chop press starts the game.
module lobby_controller #(
  parameter int          NAME_LEN     = 3,
  parameter logic [7:0]  CHAR_MIN     = 8'h41,
  parameter logic [7:0]  CHAR_MAX     = 8'h5A,
  parameter int          REPEAT_DELAY = 50_000_000,
  parameter int          REPEAT_RATE  = 10_000_000,
  parameter int          INTRO_CYCLES = 500_000_000,
  parameter int          CURSOR_WRAP  = 0,
  localparam int         CW = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     left,
  input  logic                     right,
  input  logic                     up,
  input  logic                     down,
  input  logic                     chop,
  input  logic                     abort,
  output logic [1:0]               phase,
  output logic [NAME_LEN-1:0][7:0] team_name,
  output logic [CW-1:0]            cursor,
  output logic                     play_start
);

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    CONFIRM = 2'd1,
    INTRO   = 2'd2,
    PLAY    = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_UP   = 2'd1,
    K_DN   = 2'd2
  } key_t;

  localparam int MAX_AB  = (INTRO_CYCLES > REPEAT_DELAY) ?
                           INTRO_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_AB > REPEAT_RATE) ?
                           MAX_AB : REPEAT_RATE;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] INTRO_C = CNT_W'(INTRO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CW-1:0]    LAST    = CW'(NAME_LEN - 1);
  localparam logic [CW-1:0]    CUR_ONE = CW'(1);

  phase_t                     phase_q, phase_n;
  logic [NAME_LEN-1:0][7:0]   name_q, name_n;
  logic [CW-1:0]              cursor_q, cursor_n;
  logic [CNT_W-1:0]           cnt_q, cnt_n;
  key_t                       key_q, key_n;
  logic                       fast_q, fast_n;
  logic                       start_q, start_n;
  logic [4:0]                 prev_q;

  logic [4:0]                 btn;
  logic [4:0]                 press;
  logic [CW-1:0]              sel;
  logic [7:0]                 cur_char;
  logic [7:0]                 rep_char;
  logic                       held;

  // up moves toward CHAR_MIN, wrapping to CHAR_MAX
  function automatic logic [7:0] dec_char(input logic [7:0] c);
    return (c == CHAR_MIN) ? CHAR_MAX : c - 8'd1;
  endfunction

  // down moves toward CHAR_MAX, wrapping to CHAR_MIN
  function automatic logic [7:0] inc_char(input logic [7:0] c);
    return (c == CHAR_MAX) ? CHAR_MIN : c + 8'd1;
  endfunction

  assign btn      = {chop, up, down, right, left};
  assign press    = btn & ~prev_q;
  assign sel      = LAST - cursor_q;
  assign cur_char = name_q[sel];
  assign held     = (key_q == K_UP && up) ||
                    (key_q == K_DN && down);
  assign rep_char = (key_q == K_UP) ?
                    dec_char(cur_char) : inc_char(cur_char);

  assign phase      = phase_q;
  assign team_name  = name_q;
  assign cursor     = cursor_q;
  assign play_start = start_q;

  // state register; button history always tracks the live levels
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q  <= MENU;
      name_q   <= {NAME_LEN{CHAR_MIN}};
      cursor_q <= '0;
      cnt_q    <= '0;
      key_q    <= K_NONE;
      fast_q   <= 1'b0;
      start_q  <= 1'b0;
      prev_q   <= 5'b11111;
    end else begin
      phase_q  <= phase_n;
      name_q   <= name_n;
      cursor_q <= cursor_n;
      cnt_q    <= cnt_n;
      key_q    <= key_n;
      fast_q   <= fast_n;
      start_q  <= start_n;
      prev_q   <= btn;
    end
  end

  // next-state: editing, auto-repeat, phase sequencing
  always_comb begin
    phase_n  = phase_q;
    name_n   = name_q;
    cursor_n = cursor_q;
    cnt_n    = cnt_q;
    key_n    = key_q;
    fast_n   = fast_q;
    start_n  = 1'b0;
    unique case (phase_q)
      MENU: begin
        priority case (1'b1)
          press[4]: begin
            phase_n = CONFIRM;
            cnt_n   = '0;
            key_n   = K_NONE;
            fast_n  = 1'b0;
          end
          press[3]: begin
            name_n[sel] = dec_char(cur_char);
            key_n       = K_UP;
            cnt_n       = CNT_ONE;
            fast_n      = 1'b0;
          end
          press[2]: begin
            name_n[sel] = inc_char(cur_char);
            key_n       = K_DN;
            cnt_n       = CNT_ONE;
            fast_n      = 1'b0;
          end
          default: begin
            if (held) begin
              if (!fast_q && cnt_q >= DELAY_C) begin
                name_n[sel] = rep_char;
                cnt_n       = CNT_ONE;
                fast_n      = 1'b1;
              end else if (fast_q && cnt_q >= RATE_C) begin
                name_n[sel] = rep_char;
                cnt_n       = CNT_ONE;
              end else begin
                cnt_n = cnt_q + CNT_ONE;
              end
            end else begin
              cnt_n  = '0;
              key_n  = K_NONE;
              fast_n = 1'b0;
            end
            if (NAME_LEN > 1 && !(up || down)) begin
              if (press[1]) begin
                if (cursor_q == LAST)
                  cursor_n = (CURSOR_WRAP != 0) ? '0 : cursor_q;
                else
                  cursor_n = cursor_q + CUR_ONE;
              end else if (press[0]) begin
                if (cursor_q == '0)
                  cursor_n = (CURSOR_WRAP != 0) ? LAST : cursor_q;
                else
                  cursor_n = cursor_q - CUR_ONE;
              end
            end
          end
        endcase
      end
      CONFIRM: begin
        if (!chop) begin
          phase_n  = INTRO;
          cursor_n = '0;
          cnt_n    = INTRO_C;
        end
      end
      INTRO: begin
        if (abort) begin
          phase_n  = MENU;
          cursor_n = '0;
          cnt_n    = '0;
        end else if (cnt_q == '0) begin
          phase_n = PLAY;
          start_n = 1'b1;
        end else begin
          cnt_n = cnt_q - CNT_ONE;
        end
      end
      PLAY: begin
        if (abort) begin
          phase_n  = MENU;
          cursor_n = '0;
          cnt_n    = '0;
        end
      end
      default: phase_n = MENU;
    endcase
  end

endmodule
